data_cache: RTL and testbench
=============================

# data_cache

Direct-mapped, write-through, no-write-allocate data cache between the single-cycle core's data-memory port (ALU_result address, Read_data_2 store data, MemRead/MemWrite, Read_data return) and a slower backing memory.
- Read hits return data combinationally in the same cycle, so the core behaves exactly as with the ideal data memory.
- Misses and all stores raise Stall, which freezes the PC and the register write until the backing memory completes.

## Interface
Parameters:
- INDEX_BITS, 4, number of line-index bits (2^INDEX_BITS lines).
- WORDS_PER_LINE, 4, 32-bit words per line; fixed at 4 (offset bits [3:2]).

Ports:
- CLK  in  1  clock. Single clock domain.
- RESET  in  1  asynchronous, active-high reset.
- Address  in  32  byte address from the core; bits [1:0] are ignored.
- Write_data  in  32  store data from the core.
- MemRead  in  1  load request.
- MemWrite  in  1  store request. Has priority if asserted together with MemRead.
- Read_data  out  32  load data. Equals the hit word when MemRead is set and the access hits; 0 otherwise.
- Stall  out  1  combinational. Holds the core.
- Mem_req  out  1  registered. Backing-memory request.
- Mem_we  out  1  registered. 1 = write, 0 = read.
- Mem_addr  out  32  registered. Word-aligned address; bits [1:0] are always 0.
- Mem_wdata  out  32  registered. Write data.
- Mem_rdata  in  32  read data. Valid in the Mem_ack cycle.
- Mem_ack  in  1  one-cycle completion pulse. Only legal while Mem_req is high.

## Operation
- Address split: tag = [31:4+INDEX_BITS], index = [3+INDEX_BITS:4], word = [3:2].
- Per-line state: valid bit, tag, 4 data words.
- hit = valid[index] & (tag match).
- FSM states are IDLE, FILL and WRITE.
- IDLE:
  - Neither request set: Stall=0.
  - MemRead & hit: Read_data = word, Stall=0.
  - MemRead & miss: Stall=1. At the clock edge, capture tag/index, set cnt=0, drive Mem_req=1, Mem_we=0, Mem_addr={tag,index,2'b00,2'b00}, then go to FILL.
  - MemWrite (hit or miss): Stall=1. At the clock edge, drive Mem_req=1, Mem_we=1, Mem_addr={Address[31:2],2'b00}, Mem_wdata=Write_data, then go to WRITE.
- FILL:
  - Stall=1 throughout.
  - On each Mem_ack, store Mem_rdata into word cnt and increment cnt.
  - Mem_req stays high and Mem_addr advances to the next word at the edge.
  - On the ack with cnt=3: set valid and tag, drop Mem_req, return to IDLE. The core's retried load then hits.
- WRITE:
  - Stall = ~Mem_ack.
  - On Mem_ack:
    - If the line hits, update the cached word with the captured data.
    - Drop Mem_req and Mem_we and return to IDLE.
  - The core advances at this same edge, so the store is never issued twice.
  - A write miss leaves the cache contents unchanged.
- Request inputs are held stable by the core while Stall=1. Changes to them while in FILL or WRITE are ignored.
- A Mem_ack received while Mem_req=0 is ignored.

## Timing
- Reset values:
  - Stall=0, Read_data=0, Mem_req=0, Mem_we=0, Mem_addr=0, Mem_wdata=0.
  - All valid bits 0, state IDLE, cnt=0.
  - Data and tag arrays need no reset.
- Reset asserted mid-FILL or mid-WRITE: abort immediately, Mem_req drops asynchronously, and the partially filled line stays invalid.
- L = cycles Mem_req is visible per access, including the ack cycle (L ≥ 1; ack in the first cycle is legal).
- Read hit: 0 stall cycles.
- Read miss: 1 detect cycle + 4·L FILL cycles stalled, then a hit cycle with Stall=0.
- Store: 1 detect cycle + (L−1) WRITE cycles stalled. Stall=0 in the ack cycle.
- Mem_addr and Mem_wdata are stable for every cycle in which Mem_req=1 and Mem_ack=0.

## Structure
- Shared memory-subsystem header holds:
  - state encodings: IDLE=2'd0, FILL=2'd1, WRITE=2'd2
  - WORD_OFFSET_BITS=2 and BYTE_OFFSET_BITS=2
  - the Mem_* handshake description, reused by a future instruction cache
- One sub-module, dcache_array:
  - valid/tag/data storage indexed by index and word
  - combinational read, synchronous write of word and line-valid
  - asynchronous clear of the valid bits
- FSM, counter and handshake logic live in data_cache.

## Test plan
- Cold load: reset, MemRead at 0x0000_0040, memory holds 0x11,0x22,0x33,0x44 at 0x40..0x4C with L=2.
  - Required: Stall high for 9 cycles, Mem_addr sequence 0x40, 0x44, 0x48, 0x4C, then Read_data=0x11 with Stall=0.
  - Then a load at 0x4C returns 0x44 with 0 stall.
- Store hit: after the fill above, store 0xDEAD_BEEF to 0x44 with L=1.
  - Required: Mem_we=1, Mem_addr=0x44, Stall for exactly 1 cycle.
  - A following load at 0x44 returns 0xDEAD_BEEF with no Mem_req.
- Store miss: store 0x5 to 0x1000_0000.
  - Required: memory write issued, valid bits unchanged.
  - A following load at that address misses and fills.
- Conflict eviction (INDEX_BITS=4): load 0x40, then 0x440, then 0x40.
  - Required: three fills, since the second evicts the first.
- Reset mid-FILL: assert RESET after the second ack.
  - Required: Mem_req=0 immediately.
  - After release, a load at the same address refetches all 4 words.
- Ack-in-first-cycle and stray ack: L=1 fill completes in 4 FILL cycles, and a Mem_ack pulse while in IDLE causes no state change.

Source files
------------

// File: rtl/data_cache_pkg.sv
// Shared memory-subsystem definitions for the data cache (and a future
// instruction cache that will speak the same backing-memory handshake).
//
// Backing-memory handshake (valid/ready style, requester side = cache):
//   Mem_req is the request-valid. While Mem_req=1 the requester holds
//   Mem_we, Mem_addr and Mem_wdata stable. The memory answers with a
//   single-cycle Mem_ack pulse (the "ready"), which may arrive in the very
//   first Mem_req cycle. For reads, Mem_rdata is valid only in the Mem_ack
//   cycle. The request completes at the clock edge that ends the ack cycle.
//   A Mem_ack seen while Mem_req=0 carries no meaning and is ignored.
package data_cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam int WORD_OFFSET_BITS = 2;
  localparam int BYTE_OFFSET_BITS = 2;

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage for the direct-mapped data cache.
// Combinational read of one word plus its line's valid bit and tag;
// synchronous writes of a single data word and of a line's valid/tag.
// Valid bits clear asynchronously on reset; tags and data are not reset.
module dcache_array
  import data_cache_pkg::*;
#(
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS   = 24
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [INDEX_BITS-1:0]       rd_index,
  input  logic [WORD_OFFSET_BITS-1:0] rd_word,
  output logic                        rd_valid,
  output logic [TAG_BITS-1:0]         rd_tag,
  output logic [31:0]                 rd_data,
  input  logic [INDEX_BITS-1:0]       wr_index,
  input  logic                        data_we,
  input  logic [WORD_OFFSET_BITS-1:0] wr_word,
  input  logic [31:0]                 wr_data,
  input  logic                        line_we,
  input  logic                        line_valid,
  input  logic [TAG_BITS-1:0]         line_tag
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int WORDS = 1 << WORD_OFFSET_BITS;

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [31:0]         data_mem [LINES][WORDS];

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index][rd_word];

  // Line valid bits: cleared by reset, set/cleared per line by the controller
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (line_we) begin
      valid[wr_index] <= line_valid;
    end
  end

  // Data words and tags: plain storage, tag only written when a line becomes valid
  always_ff @(posedge clk) begin
    if (data_we) begin
      data_mem[wr_index][wr_word] <= wr_data;
    end
    if (line_we && line_valid) begin
      tag_mem[wr_index] <= line_tag;
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache sitting between
// a single-cycle core's data port and a slower backing memory. Read hits are
// answered combinationally; misses and every store stall the core until the
// backing memory completes.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int INDEX_BITS     = 4,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] Read_data,
  output logic        Stall,
  output logic        Mem_req,
  output logic        Mem_we,
  output logic [31:0] Mem_addr,
  output logic [31:0] Mem_wdata,
  input  logic [31:0] Mem_rdata,
  input  logic        Mem_ack,
  output state_t      dbg_state
);

  localparam int OFF_BITS = $clog2(WORDS_PER_LINE) + BYTE_OFFSET_BITS;
  localparam int TAG_BITS = 32 - OFF_BITS - INDEX_BITS;
  localparam logic [WORD_OFFSET_BITS-1:0] LAST_WORD = WORD_OFFSET_BITS'(WORDS_PER_LINE - 1);

  state_t                      state;
  logic [WORD_OFFSET_BITS-1:0] cnt;
  logic                        wr_hit;
  logic                        ack;

  logic [TAG_BITS-1:0]         req_tag;
  logic [INDEX_BITS-1:0]       req_index;
  logic [WORD_OFFSET_BITS-1:0] req_word;
  logic                        hit;

  logic                        rd_valid;
  logic [TAG_BITS-1:0]         rd_tag;
  logic [31:0]                 rd_data;

  logic [INDEX_BITS-1:0]       wr_index;
  logic                        data_we;
  logic [WORD_OFFSET_BITS-1:0] wr_word;
  logic [31:0]                 wr_data;
  logic                        line_we;
  logic                        line_valid;

  assign req_tag   = Address[31 -: TAG_BITS];
  assign req_index = Address[OFF_BITS +: INDEX_BITS];
  assign req_word  = Address[BYTE_OFFSET_BITS +: WORD_OFFSET_BITS];

  // An ack only counts while a request is outstanding
  assign ack       = Mem_ack & Mem_req;
  assign hit       = rd_valid && (rd_tag == req_tag);
  assign dbg_state = state;

  dcache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk        (CLK),
    .rst        (RESET),
    .rd_index   (req_index),
    .rd_word    (req_word),
    .rd_valid   (rd_valid),
    .rd_tag     (rd_tag),
    .rd_data    (rd_data),
    .wr_index   (wr_index),
    .data_we    (data_we),
    .wr_word    (wr_word),
    .wr_data    (wr_data),
    .line_we    (line_we),
    .line_valid (line_valid),
    .line_tag   (Mem_addr[31 -: TAG_BITS])
  );

  // Core-facing response: hit data and stall, forced quiet while in reset
  always_comb begin
    Stall     = 1'b0;
    Read_data = '0;
    if (!RESET) begin
      case (state)
        IDLE: begin
          if (MemWrite) begin
            Stall = 1'b1;
          end else if (MemRead) begin
            if (hit) begin
              Read_data = rd_data;
            end else begin
              Stall = 1'b1;
            end
          end
        end
        FILL:    Stall = 1'b1;
        // The core is released in the ack cycle so it advances at the same edge
        WRITE:   Stall = ~Mem_ack;
        default: Stall = 1'b0;
      endcase
    end
  end

  // Array write controls: invalidate on miss detect, fill words, update on write hit
  always_comb begin
    wr_index   = Mem_addr[OFF_BITS +: INDEX_BITS];
    data_we    = 1'b0;
    wr_word    = cnt;
    wr_data    = Mem_rdata;
    line_we    = 1'b0;
    line_valid = 1'b0;
    case (state)
      IDLE: begin
        // The victim line goes invalid before any of its words are overwritten,
        // so an aborted fill never leaves a half-written line looking valid
        if (!MemWrite && MemRead && !hit) begin
          wr_index = req_index;
          line_we  = 1'b1;
        end
      end
      FILL: begin
        if (ack) begin
          data_we = 1'b1;
          if (cnt == LAST_WORD) begin
            line_we    = 1'b1;
            line_valid = 1'b1;
          end
        end
      end
      WRITE: begin
        if (ack && wr_hit) begin
          data_we = 1'b1;
          wr_word = Mem_addr[BYTE_OFFSET_BITS +: WORD_OFFSET_BITS];
          wr_data = Mem_wdata;
        end
      end
      default: ;
    endcase
  end

  // Controller FSM with registered backing-memory request outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      cnt       <= '0;
      wr_hit    <= 1'b0;
      Mem_req   <= 1'b0;
      Mem_we    <= 1'b0;
      Mem_addr  <= '0;
      Mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (MemWrite) begin
            // The array cannot change while the store is outstanding, so the
            // hit seen now is still correct when the ack arrives
            Mem_req   <= 1'b1;
            Mem_we    <= 1'b1;
            Mem_addr  <= {Address[31:2], Address[1:0] & 2'b00};
            Mem_wdata <= Write_data;
            wr_hit    <= hit;
            state     <= WRITE;
          end else if (MemRead && !hit) begin
            Mem_req   <= 1'b1;
            Mem_we    <= 1'b0;
            Mem_addr  <= {req_tag, req_index, {OFF_BITS{1'b0}}};
            cnt       <= '0;
            state     <= FILL;
          end
        end
        FILL: begin
          if (ack) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_WORD) begin
              Mem_req <= 1'b0;
              state   <= IDLE;
            end else begin
              Mem_addr[BYTE_OFFSET_BITS +: WORD_OFFSET_BITS] <= cnt + 1'b1;
            end
          end
        end
        WRITE: begin
          if (ack) begin
            Mem_req <= 1'b0;
            Mem_we  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Testbench for data_cache: directed scenarios followed by randomized loads
// and stores, checked against a line-level cache model and a word-addressed
// backing-memory model.
module tb_data_cache;
  import data_cache_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Read_data;
  logic        Stall;
  logic        Mem_req;
  logic        Mem_we;
  logic [31:0] Mem_addr;
  logic [31:0] Mem_wdata;
  logic [31:0] Mem_rdata;
  logic        Mem_ack;
  state_t      dbg_state;

  always #5 CLK = ~CLK;

  data_cache dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .Address   (Address),
    .Write_data(Write_data),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Read_data (Read_data),
    .Stall     (Stall),
    .Mem_req   (Mem_req),
    .Mem_we    (Mem_we),
    .Mem_addr  (Mem_addr),
    .Mem_wdata (Mem_wdata),
    .Mem_rdata (Mem_rdata),
    .Mem_ack   (Mem_ack),
    .dbg_state (dbg_state)
  );

  // ---------------- counters and reference models ----------------
  int n_assert = 0;
  int n_fail   = 0;

  // backing memory: word address -> data; unwritten words have a fixed pattern
  logic [31:0] bmem [logic [31:0]];
  // cache contents as the rules dictate: 16 lines, tag = addr[31:8]
  bit          m_valid [16];
  logic [23:0] m_tag   [16];
  logic [31:0] m_data  [16][4];

  // scoreboard queues
  logic [31:0] exp_q[$];
  logic [31:0] obs_addr_q[$];
  logic        obs_we_q[$];
  logic [31:0] obs_wdata_q[$];

  int          req_cyc = 0;
  int          last_stall;
  logic [31:0] last_rd;
  bit          last_done;

  function automatic logic [31:0] mem_val(input logic [31:0] wa);
    if (bmem.exists(wa)) return bmem[wa];
    return wa ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Backing memory: acks the L-th cycle of each visible request. Called just after a negedge.
  task automatic mem_step(input int lat);
    Mem_ack   = 1'b0;
    Mem_rdata = '0;
    if (Mem_req) begin
      req_cyc++;
      if (req_cyc >= lat) begin
        req_cyc = 0;
        Mem_ack = 1'b1;
        obs_addr_q.push_back(Mem_addr);
        obs_we_q.push_back(Mem_we);
        obs_wdata_q.push_back(Mem_wdata);
        if (!Mem_we) Mem_rdata = mem_val(Mem_addr);
      end
    end
  endtask

  // Runs cycles until the core would advance (Stall=0), counting stalled cycles
  task automatic run_cycles(input int lat);
    last_stall = 0;
    last_done  = 1'b0;
    last_rd    = '0;
    obs_addr_q.delete();
    obs_we_q.delete();
    obs_wdata_q.delete();
    for (int c = 0; c < 100 && !last_done; c++) begin
      mem_step(lat);
      #1;
      if (Stall) begin
        last_stall++;
      end else begin
        last_done = 1'b1;
        last_rd   = Read_data;
      end
      @(negedge CLK);
    end
    Mem_ack   = 1'b0;
    Mem_rdata = '0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    check("completes_within_budget", 32'(last_done), 32'd1);
  endtask

  // One core access, predicted from the model, driven, checked, then folded into the model
  task automatic access(input string nm, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [31:0] wd, input int lat);
    logic [31:0] wa, line, exp_rd;
    logic [23:0] tg;
    int          idx, w, exp_stall;
    bit          hit;
    wa   = {addr[31:2], 2'b00};
    line = {addr[31:4], 4'h0};
    idx  = int'(addr[7:4]);
    w    = int'(addr[3:2]);
    tg   = addr[31:8];
    hit  = m_valid[idx] && (m_tag[idx] == tg);
    exp_q.delete();
    exp_rd    = '0;
    exp_stall = 0;
    if (wr) begin
      exp_stall = lat;
      exp_q.push_back(wa);
    end else if (rd) begin
      if (hit) begin
        exp_rd = m_data[idx][w];
      end else begin
        exp_stall = 1 + 4 * lat;
        for (int k = 0; k < 4; k++) exp_q.push_back(line + 32'(4 * k));
        exp_rd = mem_val(wa);
      end
    end
    MemRead    = rd;
    MemWrite   = wr;
    Address    = addr;
    Write_data = wd;
    run_cycles(lat);
    check({nm, " stall_cycles"}, 32'(last_stall), 32'(exp_stall));
    check({nm, " read_data"}, last_rd, exp_rd);
    check({nm, " mem_accesses"}, 32'(obs_addr_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_addr_q.size() > 0) begin
      check({nm, " mem_addr"}, obs_addr_q.pop_front(), exp_q.pop_front());
      check({nm, " mem_we"}, 32'(obs_we_q.pop_front()), 32'(wr));
      if (wr) check({nm, " mem_wdata"}, obs_wdata_q.pop_front(), wd);
      else void'(obs_wdata_q.pop_front());
    end
    if (wr) begin
      bmem[wa] = wd;
      if (hit) m_data[idx][w] = wd;
    end else if (rd && !hit) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      for (int k = 0; k < 4; k++) m_data[idx][k] = mem_val(line + 32'(4 * k));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RESET      = 1'b1;
    Address    = '0;
    Write_data = '0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    Mem_rdata  = '0;
    Mem_ack    = 1'b0;
    repeat (2) @(negedge CLK);

    // reset values
    check("rst Stall", 32'(Stall), 32'd0);
    check("rst Read_data", Read_data, 32'd0);
    check("rst Mem_req", 32'(Mem_req), 32'd0);
    check("rst Mem_we", 32'(Mem_we), 32'd0);
    check("rst Mem_addr", Mem_addr, 32'd0);
    check("rst Mem_wdata", Mem_wdata, 32'd0);
    check("rst state", 32'(dbg_state), 32'(IDLE));
    RESET = 1'b0;

    // cold load with L=2, then a hit in the same line
    bmem[32'h40] = 32'h11;
    bmem[32'h44] = 32'h22;
    bmem[32'h48] = 32'h33;
    bmem[32'h4C] = 32'h44;
    access("cold_load", 1'b1, 1'b0, 32'h40, 32'h0, 2);
    check("cold_load nine_stalls", 32'(last_stall), 32'd9);
    check("cold_load first_word", last_rd, 32'h11);
    access("hit_4c", 1'b1, 1'b0, 32'h4C, 32'h0, 2);
    check("hit_4c word", last_rd, 32'h44);

    // store hit with L=1, then read it back without a backing access
    access("store_hit", 1'b0, 1'b1, 32'h44, 32'hDEAD_BEEF, 1);
    check("store_hit one_stall", 32'(last_stall), 32'd1);
    access("load_44", 1'b1, 1'b0, 32'h44, 32'h0, 2);
    check("load_44 value", last_rd, 32'hDEAD_BEEF);

    // store miss leaves the cache alone; the next load there fills
    access("store_miss", 1'b0, 1'b1, 32'h1000_0000, 32'h5, 2);
    access("still_cached", 1'b1, 1'b0, 32'h48, 32'h0, 2);
    access("load_after_store_miss", 1'b1, 1'b0, 32'h1000_0000, 32'h0, 2);
    check("load_after_store_miss value", last_rd, 32'h5);

    // reset in the middle of a fill, after the second ack
    obs_addr_q.delete();
    obs_we_q.delete();
    obs_wdata_q.delete();
    MemRead = 1'b1;
    Address = 32'h2000_0080;
    for (int c = 0; c < 40 && obs_addr_q.size() < 2; c++) begin
      mem_step(1);
      @(negedge CLK);
    end
    Mem_ack = 1'b0;
    check("midfill two_acks", 32'(obs_addr_q.size()), 32'd2);
    check("midfill busy", 32'(Mem_req), 32'd1);
    RESET = 1'b1;
    #1;
    check("midfill_rst Mem_req", 32'(Mem_req), 32'd0);
    check("midfill_rst Stall", 32'(Stall), 32'd0);
    check("midfill_rst state", 32'(dbg_state), 32'(IDLE));
    @(negedge CLK);
    RESET   = 1'b0;
    MemRead = 1'b0;
    req_cyc = 0;
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    access("refetch", 1'b1, 1'b0, 32'h2000_0080, 32'h0, 2);

    // conflict eviction on index 4: three fills
    access("conflict_a", 1'b1, 1'b0, 32'h40, 32'h0, 1);
    check("conflict_a fills", 32'(last_stall), 32'd5);
    access("conflict_b", 1'b1, 1'b0, 32'h440, 32'h0, 1);
    check("conflict_b fills", 32'(last_stall), 32'd5);
    access("conflict_c", 1'b1, 1'b0, 32'h40, 32'h0, 1);
    check("conflict_c fills", 32'(last_stall), 32'd5);
    check("conflict_c word", last_rd, 32'h11);

    // stray ack while idle
    Mem_ack = 1'b1;
    #1;
    check("stray Stall", 32'(Stall), 32'd0);
    @(negedge CLK);
    Mem_ack = 1'b0;
    check("stray Mem_req", 32'(Mem_req), 32'd0);
    check("stray state", 32'(dbg_state), 32'(IDLE));
    access("after_stray", 1'b1, 1'b0, 32'h44, 32'h0, 1);

    // randomized loads and stores over a small conflicting address pool
    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      bit          is_wr;
      a = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 3)) << 4)
        | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      is_wr = ($urandom_range(0, 9) < 4);
      access(is_wr ? "rand_store" : "rand_load", !is_wr, is_wr, a, $urandom,
             int'($urandom_range(1, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
